line_window_gen: RTL and testbench
==================================

// Module: line_window_gen
// PURPOSE
//  Streaming KxK sliding-window generator for the conv front end. Generalises the fixed
//  32x32 / 5x5 line controller: image size and kernel size are parameters, stride is
//  selectable at run time, and the pixel input has ready backpressure.
//  It sits between the raster pixel source and the conv PE array. It buffers K+1 lines in a
//  ring and emits one valid-mode window per output pixel over a valid/ready handshake.
// PARAMETERS
//  DATA_W  8   pixel width (bits)
//  IMG_W   32  image width in pixels (>= K)
//  IMG_H   32  image height in pixels (>= K)
//  K       5   kernel size; odd, 3..7
//  NL      K+1 line-buffer depth in lines (localparam, not overridable)
// PORTS
//  clk               in   1            clock, rising edge
//  reset             in   1            asynchronous reset, active-high
//  i_start           in   1            1-cycle frame start; ignored unless IDLE
//  i_stride          in   2            stride S, latched at i_start; 0 is treated as 1; legal S = 1..3
//  o_done            out  1            1-cycle pulse when the frame is complete
//  pixel_in_valid    in   1            pixel_in is valid
//  o_pixel_ready     out  1            block can accept a pixel
//  pixel_in          in   DATA_W       raster-order pixel
//  o_conv_valid      out  1            o_window is valid
//  i_conv_ready      in   1            downstream accepts the window
//  o_conv_row_start  out  1            the current window is the first of its output row
//  o_conv_row_end    out  1            the current window is the last of its output row
//  o_window          out  K*K*DATA_W   element (i,j) at [(i*K+j)*DATA_W +: DATA_W]; i = row (0 = top), j = column
//  o_out_row         out  8            output row index r of the current window
//  o_out_col         out  8            output column index c of the current window
//  o_current_state   out  3            FSM state (debug)
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM in IDLE; pointers and counters 0. Reset asserted mid-frame
//    aborts the frame with no o_done. Line-buffer contents are don't-care after reset.
//  - Output size: OUT_W = (IMG_W-K)/S + 1 and OUT_H = (IMG_H-K)/S + 1 (integer division).
//    Window (r,c) has its top-left at input pixel (r*S, c*S).
//  - Input handshake: a pixel transfers when pixel_in_valid && o_pixel_ready. It is written to
//    line wr_ptr at column in_col. At in_col == IMG_W-1: wr_ptr = (wr_ptr+1) mod NL and in_row++.
//  - o_pixel_ready = busy && in_row < IMG_H && in_row < r*S + NL. The block never overwrites a
//    line that the current output row still reads.
//  - FSM states:
//    IDLE(0): on i_start, latch S and go to LOAD.
//    LOAD(1): wait until in_row >= r*S + K, then go to CONV.
//    CONV(2): scan columns; emit OUT_W windows.
//    ROLL(3): if r == OUT_H-1 go to FINISH; otherwise r++, rd_base = (rd_base+S) mod NL, go to LOAD.
//    FINISH(4): o_done = 1 for one cycle, then go to IDLE.
//  - CONV: read column x from the K lines rd_base..rd_base+K-1 (mod NL); sync RAM, 1-cycle read.
//    Shift the column into the window register, left to right. Once K columns are loaded, present
//    a window at every column x = c*S+K-1. Stop the scan after c = OUT_W-1.
//  - Output handshake: while o_conv_valid && !i_conv_ready, o_window, o_out_row, o_out_col and the
//    row flags hold stable and the column scan stalls. Input writes continue during the stall.
//    Output is registered; no combinational path from i_conv_ready to o_conv_valid.
//  - o_conv_row_start is high with window (r,0). o_conv_row_end is high with window (r,OUT_W-1).
//    When OUT_W == 1 both are high together.
//  - Simultaneous events: a pixel write and a column read in the same cycle target different lines
//    by construction, so no bypass is needed. i_start in any state other than IDLE is ignored.
// STRUCTURE
//  - Package lwin_pkg: state encodings (S_IDLE..S_FINISH), the function clog2, and the
//    OUT_W/OUT_H helper function.
//  - Sub-module lwin_line_buffer: NL banks of IMG_W x DATA_W simple dual-port RAM with a 1-cycle
//    read; K read ports selected by rd_base.
//  - The top level holds the FSM, the counters, the window shift register and the output handshake.
// TESTING
//  1. Defaults, S=1, pixel[i] = i%256, ready = 1 -> 784 windows. Window 1 has centre pixel[66].
//     Window n has centre pixel[(r+2)*32+c+2]. 28 row_start pulses; o_done pulses once.
//  2. S=2 -> 196 windows (14x14). Window (r,c) centre = pixel[(2r+2)*32+2c+2]. Last window = (13,13).
//  3. Random 50% i_conv_ready -> same 784 windows in the same order. o_window is stable on every
//     cycle with valid && !ready.
//  4. i_conv_ready = 0 held from start -> o_pixel_ready drops after 6 full rows (192 pixels)
//     and stays low. Then release -> completes normally.
//  5. K=3, IMG_W=16, IMG_H=8, S=1 -> 84 windows. Window (0,0) = pixels {0,1,2,16,17,18,32,33,34}.
//  6. Reset asserted during output row 7 -> all outputs 0 and state 0 immediately. Re-start
//     -> full 784 windows, no stale data.

Source files
------------

// File: rtl/lwin_pkg.sv
// Shared definitions for the KxK line-window generator: FSM encodings and
// elaboration-time sizing helpers.
package lwin_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_ROLL   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // Ceiling log2, never less than 1 so it can size a port directly.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Valid-mode output extent along one axis.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                          input int unsigned s);
    return (img - k) / s + 1;
  endfunction

endpackage

// File: rtl/lwin_line_buffer.sv
// Ring of NL line banks; one write port and K synchronous read ports that
// return the K consecutive lines starting at rd_base (mod NL).
module lwin_line_buffer
  import lwin_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned K      = 5,
  parameter int unsigned NL     = 6
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [clog2(NL)-1:0]      wr_line,
  input  logic [clog2(IMG_W)-1:0]   wr_col,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic [clog2(NL)-1:0]      rd_base,
  input  logic [clog2(IMG_W)-1:0]   rd_col,
  output logic [K*DATA_W-1:0]       rd_data
);

  localparam int unsigned LW = clog2(NL);

  logic [DATA_W-1:0]   mem_q [NL][IMG_W];
  logic [K*DATA_W-1:0] rd_data_q;
  logic [LW-1:0]       rd_line [K];
  logic [LW:0]         line_sum;

  // Physical bank for each window row, wrapping around the ring.
  always_comb begin
    line_sum = '0;
    for (int i = 0; i < int'(K); i++) begin
      line_sum   = {1'b0, rd_base} + (LW+1)'(i);
      rd_line[i] = (line_sum >= (LW+1)'(NL)) ? LW'(line_sum - (LW+1)'(NL)) : LW'(line_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_line][wr_col] <= wr_data;
  end

  // Read data holds when no read is issued, so a stalled column is not lost.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < int'(K); i++) begin
        rd_data_q[i*DATA_W +: DATA_W] <= mem_q[rd_line[i]][rd_col];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_window_gen.sv
// Streaming KxK sliding-window generator: buffers K+1 raster lines and emits
// one valid-mode window per output pixel over a valid/ready handshake.
module line_window_gen
  import lwin_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned K      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [1:0]               i_stride,
  output logic                     o_done,
  input  logic                     pixel_in_valid,
  output logic                     o_pixel_ready,
  input  logic [DATA_W-1:0]        pixel_in,
  output logic                     o_conv_valid,
  input  logic                     i_conv_ready,
  output logic                     o_conv_row_start,
  output logic                     o_conv_row_end,
  output logic [K*K*DATA_W-1:0]    o_window,
  output logic [7:0]               o_out_row,
  output logic [7:0]               o_out_col,
  output logic [2:0]               o_current_state
);

  localparam int unsigned NL  = K + 1;
  localparam int unsigned LW  = clog2(NL);
  localparam int unsigned AW  = clog2(IMG_W);
  localparam int unsigned CW  = clog2(IMG_W + 4);
  localparam int unsigned RW  = clog2(IMG_H + NL + 4);
  localparam int unsigned WW  = K * K * DATA_W;
  localparam int unsigned OW1 = out_dim(IMG_W, K, 1);
  localparam int unsigned OW2 = out_dim(IMG_W, K, 2);
  localparam int unsigned OW3 = out_dim(IMG_W, K, 3);
  localparam int unsigned OH1 = out_dim(IMG_H, K, 1);
  localparam int unsigned OH2 = out_dim(IMG_H, K, 2);
  localparam int unsigned OH3 = out_dim(IMG_H, K, 3);
  localparam int unsigned LC1 = (OW1 - 1) * 1 + K - 1;
  localparam int unsigned LC2 = (OW2 - 1) * 2 + K - 1;
  localparam int unsigned LC3 = (OW3 - 1) * 3 + K - 1;

  logic [2:0]        state_q, state_d;
  logic [1:0]        stride_q, stride_d;
  logic [AW-1:0]     in_col_q, in_col_d;
  logic [RW-1:0]     in_row_q, in_row_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]     row_top_q, row_top_d;
  logic [LW-1:0]     rd_base_q, rd_base_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     x_q, x_d;
  logic              rvalid_q, rvalid_d;
  logic [CW-1:0]     rcol_q, rcol_d;
  logic [CW-1:0]     next_win_q, next_win_d;
  logic [CW-1:0]     c_q, c_d;
  logic              scan_done_q, scan_done_d;
  logic [WW-1:0]     win_q, win_d;
  logic              conv_valid_q, conv_valid_d;
  logic              row_start_q, row_start_d;
  logic              row_end_q, row_end_d;
  logic [7:0]        out_row_q, out_row_d;
  logic [7:0]        out_col_q, out_col_d;
  logic              done_q, done_d;
  logic              pix_ready_q, pix_ready_d;

  logic              wr_en_c, rd_en_c, advance_c;
  logic [LW:0]       base_sum_c;
  logic [CW-1:0]     out_w_c, last_col_c;
  logic [RW-1:0]     out_h_c;
  logic [K*DATA_W-1:0] rd_data_c;

  lwin_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .K      (K),
    .NL     (NL)
  ) u_lbuf (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_line (wr_ptr_q),
    .wr_col  (in_col_q),
    .wr_data (pixel_in),
    .rd_en   (rd_en_c),
    .rd_base (rd_base_q),
    .rd_col  (AW'(x_q)),
    .rd_data (rd_data_c)
  );

  // Output geometry for the latched stride.
  always_comb begin
    case (stride_q)
      2'd2: begin out_w_c = CW'(OW2); out_h_c = RW'(OH2); last_col_c = CW'(LC2); end
      2'd3: begin out_w_c = CW'(OW3); out_h_c = RW'(OH3); last_col_c = CW'(LC3); end
      default: begin out_w_c = CW'(OW1); out_h_c = RW'(OH1); last_col_c = CW'(LC1); end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    wr_ptr_d    = wr_ptr_q;
    row_top_d   = row_top_q;
    rd_base_d   = rd_base_q;
    r_d         = r_q;
    x_d         = x_q;
    rvalid_d    = rvalid_q;
    rcol_d      = rcol_q;
    next_win_d  = next_win_q;
    c_d         = c_q;
    scan_done_d = scan_done_q;
    win_d       = win_q;
    conv_valid_d = conv_valid_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    advance_c   = !conv_valid_q || i_conv_ready;
    base_sum_c  = {1'b0, rd_base_q} + (LW+1)'(stride_q);

    // Input side runs independently of the scan, including during output stalls.
    if (pixel_in_valid && pix_ready_q) begin
      wr_en_c = 1'b1;
      if (in_col_q == AW'(IMG_W - 1)) begin
        in_col_d = '0;
        in_row_d = in_row_q + RW'(1);
        wr_ptr_d = (wr_ptr_q == LW'(NL - 1)) ? '0 : wr_ptr_q + LW'(1);
      end else begin
        in_col_d = in_col_q + AW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          stride_d  = (i_stride == 2'd0) ? 2'd1 : i_stride;
          in_col_d  = '0;
          in_row_d  = '0;
          wr_ptr_d  = '0;
          row_top_d = '0;
          rd_base_d = '0;
          r_d       = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_row_q >= row_top_q + RW'(K)) begin
          x_d         = '0;
          rvalid_d    = 1'b0;
          next_win_d  = CW'(K - 1);
          c_d         = '0;
          scan_done_d = 1'b0;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        if (advance_c) begin
          conv_valid_d = 1'b0;
          row_start_d  = 1'b0;
          row_end_d    = 1'b0;
          if (scan_done_q) begin
            state_d = S_ROLL;
          end else begin
            if (rvalid_q) begin
              for (int i = 0; i < int'(K); i++) begin
                for (int j = 0; j < int'(K) - 1; j++) begin
                  win_d[(i*K+j)*DATA_W +: DATA_W] = win_q[(i*K+j+1)*DATA_W +: DATA_W];
                end
                win_d[(i*K+K-1)*DATA_W +: DATA_W] = rd_data_c[i*DATA_W +: DATA_W];
              end
              if (rcol_q == next_win_q) begin
                conv_valid_d = 1'b1;
                out_row_d    = 8'(r_q);
                out_col_d    = 8'(c_q);
                row_start_d  = (c_q == '0);
                row_end_d    = (c_q == out_w_c - CW'(1));
                scan_done_d  = (c_q == out_w_c - CW'(1));
                c_d          = c_q + CW'(1);
                next_win_d   = next_win_q + CW'(stride_q);
              end
            end
            rd_en_c  = (x_q <= last_col_c);
            rvalid_d = rd_en_c;
            rcol_d   = x_q;
            if (rd_en_c) x_d = x_q + CW'(1);
          end
        end
      end
      S_ROLL: begin
        if (r_q == out_h_c - RW'(1)) begin
          state_d = S_FINISH;
        end else begin
          r_d       = r_q + RW'(1);
          row_top_d = row_top_q + RW'(stride_q);
          rd_base_d = (base_sum_c >= (LW+1)'(NL)) ? LW'(base_sum_c - (LW+1)'(NL))
                                                  : LW'(base_sum_c);
          state_d   = S_LOAD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    done_d = (state_d == S_FINISH);
    // Never accept a row that would land on a line the current output row reads.
    pix_ready_d = (state_d != S_IDLE) && (in_row_d < RW'(IMG_H)) &&
                  (in_row_d < row_top_d + RW'(NL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      stride_q     <= '0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      wr_ptr_q     <= '0;
      row_top_q    <= '0;
      rd_base_q    <= '0;
      r_q          <= '0;
      x_q          <= '0;
      rvalid_q     <= 1'b0;
      rcol_q       <= '0;
      next_win_q   <= '0;
      c_q          <= '0;
      scan_done_q  <= 1'b0;
      win_q        <= '0;
      conv_valid_q <= 1'b0;
      row_start_q  <= 1'b0;
      row_end_q    <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      done_q       <= 1'b0;
      pix_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stride_q     <= stride_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      wr_ptr_q     <= wr_ptr_d;
      row_top_q    <= row_top_d;
      rd_base_q    <= rd_base_d;
      r_q          <= r_d;
      x_q          <= x_d;
      rvalid_q     <= rvalid_d;
      rcol_q       <= rcol_d;
      next_win_q   <= next_win_d;
      c_q          <= c_d;
      scan_done_q  <= scan_done_d;
      win_q        <= win_d;
      conv_valid_q <= conv_valid_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      done_q       <= done_d;
      pix_ready_q  <= pix_ready_d;
    end
  end

  assign o_done           = done_q;
  assign o_pixel_ready    = pix_ready_q;
  assign o_conv_valid     = conv_valid_q;
  assign o_conv_row_start = row_start_q;
  assign o_conv_row_end   = row_end_q;
  assign o_window         = win_q;
  assign o_out_row        = out_row_q;
  assign o_out_col        = out_col_q;
  assign o_current_state  = state_q;

endmodule

// File: tb/tb_line_window_gen.sv
// Randomised bench for line_window_gen: windows are predicted from a stored
// image and the (row, col) sequence, independent of the scan mechanics.
`timescale 1ns/1ps
module tb_line_window_gen;

  localparam int DW = 8;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int KK = 5;
  localparam int W3 = 16;
  localparam int H3 = 8;
  localparam int K3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, i_start, o_done, pixel_in_valid, o_pixel_ready;
  logic [1:0] i_stride;
  logic [DW-1:0] pixel_in;
  logic o_conv_valid, i_conv_ready, o_conv_row_start, o_conv_row_end;
  logic [KK*KK*DW-1:0] o_window;
  logic [7:0] o_out_row, o_out_col;
  logic [2:0] o_current_state;

  logic s_start, s_done, s_pix_valid, s_pix_ready, s_valid, s_ready, s_rs, s_re;
  logic [1:0] s_stride;
  logic [DW-1:0] s_pix;
  logic [K3*K3*DW-1:0] s_window;
  logic [7:0] s_row, s_col;
  logic [2:0] s_state;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] img [W*H];

  line_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(KK)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stride(i_stride), .o_done(o_done),
    .pixel_in_valid(pixel_in_valid), .o_pixel_ready(o_pixel_ready), .pixel_in(pixel_in),
    .o_conv_valid(o_conv_valid), .i_conv_ready(i_conv_ready),
    .o_conv_row_start(o_conv_row_start), .o_conv_row_end(o_conv_row_end),
    .o_window(o_window), .o_out_row(o_out_row), .o_out_col(o_out_col),
    .o_current_state(o_current_state)
  );

  line_window_gen #(.DATA_W(DW), .IMG_W(W3), .IMG_H(H3), .K(K3)) dut_small (
    .clk(clk), .reset(reset), .i_start(s_start), .i_stride(s_stride), .o_done(s_done),
    .pixel_in_valid(s_pix_valid), .o_pixel_ready(s_pix_ready), .pixel_in(s_pix),
    .o_conv_valid(s_valid), .i_conv_ready(s_ready),
    .o_conv_row_start(s_rs), .o_conv_row_end(s_re),
    .o_window(s_window), .o_out_row(s_row), .o_out_col(s_col),
    .o_current_state(s_state)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window (r,c): element (i,j) is input pixel (r*s+i, c*s+j).
  function automatic logic [KK*KK*DW-1:0] exp_win(input int r, input int c, input int s);
    logic [KK*KK*DW-1:0] v;
    v = '0;
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++)
        v[(i*KK+j)*DW +: DW] = img[(r*s+i)*W + c*s + j];
    return v;
  endfunction

  function automatic logic [K3*K3*DW-1:0] exp_small(input int r, input int c);
    logic [K3*K3*DW-1:0] v;
    v = '0;
    for (int i = 0; i < K3; i++)
      for (int j = 0; j < K3; j++)
        v[(i*K3+j)*DW +: DW] = 8'(((r+i)*W3 + c + j) % 256);
    return v;
  endfunction

  // rmode: 0 ready=1, 1 random ready, 2 ready held low for a long stall.
  // pmode: 0 pixel[i]=i%256 always valid, 1 random pixels with random valid gaps.
  task automatic run_frame(input int s_in, input int rmode, input int pmode,
                           input int abort_row, input int exp_total);
    int s, ow, oh, n_acc, px, rs_cnt, done_cnt, stall_left;
    bit finished, aborted, fire_px, fire_w, smp_rs;
    logic [7:0] smp_row, smp_col, smp_centre;
    logic [KK*KK*DW-1:0] ew;
    s = (s_in == 0) ? 1 : s_in;
    ow = (W - KK) / s + 1;
    oh = (H - KK) / s + 1;
    n_acc = 0; px = 0; rs_cnt = 0; done_cnt = 0;
    finished = 0; aborted = 0;
    smp_rs = 0; smp_row = 0; smp_col = 0; smp_centre = 0;
    stall_left = (rmode == 2) ? 800 : 0;
    for (int i = 0; i < W*H; i++) img[i] = (pmode != 0) ? 8'($urandom_range(255)) : 8'(i % 256);

    @(posedge clk); #1;
    i_start = 1'b1; i_stride = 2'(s_in);
    @(posedge clk); #1;
    i_start = 1'b0;
    pixel_in_valid = 1'b1;
    pixel_in = img[0];
    i_conv_ready = (rmode == 0) ? 1'b1 : ((rmode == 1) ? 1'($urandom_range(1)) : 1'b0);

    for (int cyc = 0; cyc < 40000 && !finished && !aborted; cyc++) begin
      @(negedge clk);
      if (o_conv_valid) begin
        if (n_acc < ow*oh) begin
          ew = exp_win(n_acc / ow, n_acc % ow, s);
          check("win_data", 256'(o_window), 256'(ew));
          check("win_pos", 256'({o_out_row, o_out_col, o_conv_row_start, o_conv_row_end}),
                256'({8'(n_acc / ow), 8'(n_acc % ow), (n_acc % ow) == 0, (n_acc % ow) == ow - 1}));
        end else begin
          check("extra_window", 256'(n_acc), 256'(exp_total - 1));
        end
      end
      if (o_done) begin done_cnt++; finished = 1; end
      if (stall_left == 1) begin
        check("stall_pixels", 256'(px), 256'(192));
        check("stall_pixel_ready", 256'(o_pixel_ready), 256'(0));
      end
      if (abort_row >= 0 && o_conv_valid && int'(o_out_row) == abort_row) begin
        reset = 1'b1;
        #1;
        check("abort_outputs", 256'({o_done, o_pixel_ready, o_conv_valid, o_conv_row_start,
                                     o_conv_row_end, o_out_row, o_out_col, o_current_state}), 256'(0));
        check("abort_window", 256'(o_window), 256'(0));
        aborted = 1;
      end else begin
        fire_px = pixel_in_valid && o_pixel_ready;
        fire_w = o_conv_valid && i_conv_ready;
        smp_rs = o_conv_row_start;
        smp_row = o_out_row;
        smp_col = o_out_col;
        smp_centre = o_window[12*DW +: DW];
        @(posedge clk); #1;
        if (fire_px) px++;
        if (fire_w) begin
          if (n_acc == 0 && pmode == 0 && s == 1) check("first_centre", 256'(smp_centre), 256'(66));
          if (n_acc == exp_total - 1 && s == 2)
            check("last_window_rc", 256'({smp_row, smp_col}), 256'({8'd13, 8'd13}));
          if (smp_rs) rs_cnt++;
          n_acc++;
        end
        if (fire_px || !pixel_in_valid) begin
          if (px < W*H) begin
            pixel_in_valid = (pmode != 0) ? ($urandom_range(3) != 0) : 1'b1;
            pixel_in = img[px];
          end else begin
            pixel_in_valid = 1'b0;
          end
        end
        case (rmode)
          0: i_conv_ready = 1'b1;
          1: i_conv_ready = 1'($urandom_range(1));
          default: i_conv_ready = (stall_left > 1) ? 1'b0 : 1'b1;
        endcase
        if (stall_left > 0) stall_left--;
      end
    end

    pixel_in_valid = 1'b0;
    i_conv_ready = 1'b0;
    if (abort_row >= 0) begin
      check("abort_hit", 256'(aborted), 256'(1));
      check("abort_no_done", 256'(done_cnt), 256'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      check("frame_done", 256'(finished), 256'(1));
      check("window_count", 256'(n_acc), 256'(exp_total));
      check("row_starts", 256'(rs_cnt), 256'(oh));
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (o_done) done_cnt++;
      end
      check("done_pulses", 256'(done_cnt), 256'(1));
      check("idle_after", 256'(o_current_state), 256'(0));
    end
  endtask

  task automatic run_small();
    int n3, px3;
    bit fin, fire;
    logic [K3*K3*DW-1:0] lit;
    n3 = 0; px3 = 0; fin = 0;
    lit = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
    @(posedge clk); #1;
    s_start = 1'b1; s_stride = 2'd1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_pix_valid = 1'b1; s_pix = 8'd0; s_ready = 1'b1;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge clk);
      if (s_valid) begin
        check("small_data", 256'(s_window), 256'(exp_small(n3 / 14, n3 % 14)));
        check("small_pos", 256'({s_row, s_col, s_rs, s_re}),
              256'({8'(n3 / 14), 8'(n3 % 14), (n3 % 14) == 0, (n3 % 14) == 13}));
        if (n3 == 0) check("small_first_literal", 256'(s_window), 256'(lit));
        n3++;
      end
      if (s_done) fin = 1;
      fire = s_pix_valid && s_pix_ready;
      @(posedge clk); #1;
      if (fire) px3++;
      s_pix_valid = (px3 < W3*H3);
      s_pix = 8'(px3 % 256);
    end
    s_pix_valid = 1'b0;
    check("small_done", 256'(fin), 256'(1));
    check("small_count", 256'(n3), 256'(84));
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0; i_stride = 2'd0; pixel_in_valid = 1'b0; pixel_in = '0; i_conv_ready = 1'b0;
    s_start = 1'b0; s_stride = 2'd0; s_pix_valid = 1'b0; s_pix = '0; s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 256'({o_done, o_pixel_ready, o_conv_valid, o_conv_row_start,
                                 o_conv_row_end, o_out_row, o_out_col, o_current_state}), 256'(0));
    check("reset_window", 256'(o_window), 256'(0));
    reset = 1'b0;

    run_frame(1, 0, 0, -1, 784);
    run_frame(2, 0, 0, -1, 196);
    run_frame(1, 1, 1, -1, 784);
    run_frame(1, 2, 0, -1, 784);
    run_frame(0, 1, 1, 7, 0);
    run_frame(1, 1, 1, -1, 784);
    run_frame(3, 1, 1, -1, 100);
    run_small();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
